// File: rtl/param_controller.sv
// Parametrised multi-cycle control FSM for the lab processor: fetch/decode/execute sequencing,
// illegal-opcode pulse and saturating retired-instruction counter. Optional macro: CTRL_SINGLE_STEP_EN.
module param_controller #(
    parameter int IW    = 16,
    parameter int RAW   = 4,
    parameter int DAW   = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IW-1:0]    instruction,
    input  logic             rf_ra_zero,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic [3:0]       state_o,
    output logic             pc_clr,
    output logic             pc_up,
    output logic             pc_ld,
    output logic [DAW-1:0]   pc_offset,
    output logic             ld,
    output logic [DAW-1:0]   d_addr,
    output logic             d_wr,
    output logic [1:0]       rf_s,
    output logic [DAW-1:0]   imm,
    output logic [RAW-1:0]   rf_w_addr,
    output logic             rf_w_wr,
    output logic [RAW-1:0]   rf_ra_addr,
    output logic             rf_ra_rd,
    output logic [RAW-1:0]   rf_rb_addr,
    output logic             rf_rb_rd,
    output logic [2:0]       alu_s0,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_NOOP   = 4'd3;
    localparam logic [3:0] S_STORE  = 4'd4;
    localparam logic [3:0] S_LD_A   = 4'd5;
    localparam logic [3:0] S_LD_B   = 4'd6;
    localparam logic [3:0] S_ADD    = 4'd7;
    localparam logic [3:0] S_SUB    = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;
    localparam logic [3:0] S_LDC    = 4'd10;
    localparam logic [3:0] S_JZ_A   = 4'd11;
    localparam logic [3:0] S_JZ_B   = 4'd12;
    localparam logic [3:0] S_WAIT   = 4'd13;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             zero_q, zero_d;

    logic [3:0]     opcode;
    logic [RAW-1:0] f_ra, f_rb, f_rd;
    logic [DAW-1:0] f_mem, f_low;
    logic           is_final;

    assign opcode = instruction[IW-1 -: 4];
    assign f_ra   = instruction[IW-5 -: RAW];
    assign f_rb   = instruction[IW-5-RAW -: RAW];
    assign f_rd   = instruction[RAW-1:0];
    assign f_mem  = instruction[RAW +: DAW];
    assign f_low  = instruction[DAW-1:0];

    assign is_final = (state_q == S_NOOP) || (state_q == S_LD_B) || (state_q == S_STORE) ||
                      (state_q == S_ADD)  || (state_q == S_SUB)  || (state_q == S_LDC)   ||
                      (state_q == S_JZ_B);

    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    4'd0:    state_d = S_NOOP;
                    4'd1:    state_d = S_STORE;
                    4'd2:    state_d = S_LD_A;
                    4'd3:    state_d = S_ADD;
                    4'd4:    state_d = S_SUB;
                    4'd5:    state_d = S_HALT;
                    4'd6:    state_d = S_LDC;
                    4'd7:    state_d = S_JZ_A;
                    default: state_d = S_NOOP;
                endcase
            end
            S_LD_A:   state_d = S_LD_B;
            S_JZ_A:   state_d = S_JZ_B;
            S_HALT:   state_d = S_HALT;
            S_NOOP, S_LD_B, S_STORE, S_ADD, S_SUB, S_LDC, S_JZ_B:
`ifdef CTRL_SINGLE_STEP_EN
                state_d = S_WAIT;
            S_WAIT:   state_d = step ? S_FETCH : S_WAIT;
`else
                state_d = S_FETCH;
`endif
            default:  state_d = S_INIT;
        endcase
    end

    // Retirement is counted on leaving the final execute state, never in WAIT or HALT.
    always_comb begin
        count_d = count_q;
        if (is_final && (count_q != {CNT_W{1'b1}}))
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        zero_d = (state_q == S_JZ_A) ? rf_ra_zero : zero_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_INIT;
            count_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        pc_clr     = 1'b0;
        pc_up      = 1'b0;
        pc_ld      = 1'b0;
        pc_offset  = '0;
        ld         = 1'b0;
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = 2'd0;
        imm        = '0;
        rf_w_addr  = '0;
        rf_w_wr    = 1'b0;
        rf_ra_addr = '0;
        rf_ra_rd   = 1'b0;
        rf_rb_addr = '0;
        rf_rb_rd   = 1'b0;
        alu_s0     = 3'd0;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_INIT:   pc_clr = 1'b1;
            S_FETCH: begin
                ld    = 1'b1;
                pc_up = 1'b1;
            end
            S_DECODE: illegal = opcode[3];
            S_LD_A, S_LD_B: begin
                d_addr    = f_mem;
                rf_s      = 2'd1;
                rf_w_addr = f_rd;
                rf_w_wr   = (state_q == S_LD_B);
            end
            S_STORE: begin
                d_addr     = f_low;
                d_wr       = 1'b1;
                rf_ra_addr = f_ra;
                rf_ra_rd   = 1'b1;
            end
            S_ADD, S_SUB: begin
                rf_ra_addr = f_ra;
                rf_ra_rd   = 1'b1;
                rf_rb_addr = f_rb;
                rf_rb_rd   = 1'b1;
                rf_w_addr  = f_rd;
                rf_w_wr    = 1'b1;
                alu_s0     = (state_q == S_ADD) ? 3'd1 : 3'd2;
            end
            S_LDC: begin
                rf_s      = 2'd2;
                imm       = f_mem;
                rf_w_addr = f_rd;
                rf_w_wr   = 1'b1;
            end
            S_JZ_A: begin
                rf_ra_addr = f_ra;
                rf_ra_rd   = 1'b1;
            end
            S_JZ_B: begin
                pc_ld     = zero_q;
                pc_offset = f_low;
            end
            S_HALT:   halted = 1'b1;
            default: ;
        endcase
    end

    assign state_o     = state_q;
    assign instr_count = count_q;

endmodule
